// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM encodings, digit limit, din clamp helper.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package bcd_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Non-decimal nibbles (A..F) are forced to 9 so the counter only ever holds legal BCD
    function automatic logic [3:0] bcd_clamp(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD digit of the down-counter: decrements when a borrow arrives, wraps 0 -> 9 and propagates.
// Latency: purely combinational.
// Backpressure: none; borrow_in acts as the enable.
module bcd_down_digit
    import bcd_countdown_timer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       borrow_in,
    output logic [3:0] next_digit,
    output logic       borrow_out
);

    // Decrement on borrow; a zero digit rolls to 9 and passes the borrow on
    always_comb begin
        next_digit = digit;
        if (borrow_in) begin
            next_digit = (digit == 4'd0) ? BCD_MAX : (digit - 4'd1);
        end
    end

    assign borrow_out = borrow_in & (digit == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down-counter with IDLE/RUN/DONE control, pause, auto-reload from preset and expiry pulse.
// Latency: Y updates on the same clk edge that samples tick/load/start; expire is a one-cycle registered pulse.
// Backpressure: none; tick is a one-cycle strobe and is dropped when not in RUN or when load/stop win.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   Y,
    output logic                  running,
    output logic                  done,
    output logic                  expire
);

    localparam int W = 4 * DIGITS;

    state_t         state;
    state_t         state_nxt;
    logic [W-1:0]   count;
    logic [W-1:0]   count_nxt;
    logic [W-1:0]   preset;
    logic [W-1:0]   preset_nxt;
    logic           expire_nxt;
    logic [W-1:0]   din_clamped;
    logic [W-1:0]   count_dec;
    logic [DIGITS:0] borrow;
    logic           dec_en;
    logic           count_zero;
    logic           preset_zero;

    // Per-digit clamp of the preset and borrow chain for the decrement
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign din_clamped[4*i +: 4] = bcd_clamp(din[4*i +: 4]);

        bcd_down_digit u_digit (
            .digit      (count[4*i +: 4]),
            .borrow_in  (borrow[i]),
            .next_digit (count_dec[4*i +: 4]),
            .borrow_out (borrow[i+1])
        );
    end

    // Decrement only in RUN on a tick that neither load nor stop pre-empts
    assign dec_en      = (state == ST_RUN) & tick & ~load & ~stop;
    assign borrow[0]   = dec_en;
    assign count_zero  = (count == '0);
    assign preset_zero = (preset == '0);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Count, preset and expiry pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            preset <= '0;
            expire <= 1'b0;
        end else begin
            count  <= count_nxt;
            preset <= preset_nxt;
            expire <= expire_nxt;
        end
    end

    // Next-state and datapath: load > stop > start > tick
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        preset_nxt = preset;
        expire_nxt = 1'b0;
        if (load) begin
            preset_nxt = din_clamped;
            count_nxt  = din_clamped;
            state_nxt  = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    // stop has nothing to pause here, so start is honoured alongside it
                    if (start) begin
                        state_nxt = count_zero ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_nxt = ST_IDLE;
                    end else if (tick && !borrow[DIGITS]) begin
                        // A borrow out of the top digit would mean a wrap below zero; never apply it
                        count_nxt = count_dec;
                        if (count_dec == '0) begin
                            state_nxt  = ST_DONE;
                            expire_nxt = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (stop) begin
                        state_nxt = ST_IDLE;
                    end else if (start) begin
                        count_nxt = preset;
                        state_nxt = preset_zero ? ST_DONE : ST_RUN;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        running = (state == ST_RUN);
        done    = (state == ST_DONE);
    end

    assign Y = count;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench for bcd_countdown_timer (DIGITS=2) with a queue scoreboard and a separate monitor.
// Latency: expectations are pushed one edge after stimulus and checked on the following falling edge.
// Backpressure: n/a.
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [7:0] din;
    logic       start;
    logic       stop;
    logic       tick;
    logic [7:0] Y;
    logic       running;
    logic       done;
    logic       expire;

    typedef struct {
        logic [7:0] y;
        logic       run;
        logic       dn;
        logic       ex;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    event chk_now;

    logic [7:0] seq12 [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                               8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

    always #5 clk = ~clk;

    bcd_countdown_timer #(.DIGITS(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .din     (din),
        .start   (start),
        .stop    (stop),
        .tick    (tick),
        .Y       (Y),
        .running (running),
        .done    (done),
        .expire  (expire)
    );

    // Monitor: drain the scoreboard on each falling edge or on an explicit request
    initial begin
        forever begin
            @(negedge clk or chk_now);
            while (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                n_vec++;
                if (Y !== e.y || running !== e.run || done !== e.dn || expire !== e.ex) begin
                    n_miss++;
                    $display("FAIL %s: got Y=%h running=%b done=%b expire=%b, want Y=%h running=%b done=%b expire=%b",
                             e.nm, Y, running, done, expire, e.y, e.run, e.dn, e.ex);
                end
            end
        end
    end

    task automatic push_exp(input logic [7:0] ey, input logic er, input logic ed, input logic ee,
                            input string nm);
        exp_t e;
        e.y   = ey;
        e.run = er;
        e.dn  = ed;
        e.ex  = ee;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic step(input logic l, input logic [7:0] d, input logic s, input logic p,
                        input logic t, input logic [7:0] ey, input logic er, input logic ed,
                        input logic ee, input string nm);
        @(negedge clk);
        load  = l;
        din   = d;
        start = s;
        stop  = p;
        tick  = t;
        @(posedge clk);
        #1;
        push_exp(ey, er, ed, ee, nm);
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        tick  = 1'b0;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b0;
        load  = 1'b0;
        din   = 8'h00;
        start = 1'b0;
        stop  = 1'b0;
        tick  = 1'b0;

        // 1: reset state
        #3;
        push_exp(8'h00, 1'b0, 1'b0, 1'b0, "reset");
        -> chk_now;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 2: count 12 down to 00
        step(1, 8'h12, 0, 0, 0, 8'h12, 0, 0, 0, "t2_load");
        step(0, 8'h00, 1, 0, 0, 8'h12, 1, 0, 0, "t2_start");
        for (int i = 0; i < 12; i++) begin
            step(0, 8'h00, 0, 0, 1, seq12[i], (i < 11), (i == 11), (i == 11), "t2_tick");
        end
        step(0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, "t2_done_hold");

        // 3: cross-digit borrow, pause, resume
        step(1, 8'h20, 0, 0, 0, 8'h20, 0, 0, 0, "t3_load");
        step(0, 8'h00, 1, 0, 0, 8'h20, 1, 0, 0, "t3_start");
        step(0, 8'h00, 0, 0, 1, 8'h19, 1, 0, 0, "t3_borrow");
        step(0, 8'h00, 0, 1, 0, 8'h19, 0, 0, 0, "t3_stop");
        for (int i = 0; i < 3; i++) begin
            step(0, 8'h00, 0, 0, 1, 8'h19, 0, 0, 0, "t3_paused_tick");
        end
        step(0, 8'h00, 1, 0, 0, 8'h19, 1, 0, 0, "t3_resume");
        step(0, 8'h00, 0, 0, 1, 8'h18, 1, 0, 0, "t3_tick");
        step(0, 8'h00, 1, 1, 1, 8'h18, 0, 0, 0, "t3_start_stop_run");
        step(0, 8'h00, 1, 1, 0, 8'h18, 1, 0, 0, "t3_start_stop_idle");

        // 4: clamping of invalid digits
        step(1, 8'h3C, 0, 0, 0, 8'h39, 0, 0, 0, "t4_clamp_d0");
        step(1, 8'hC5, 0, 0, 0, 8'h95, 0, 0, 0, "t4_clamp_d1");
        step(1, 8'hFA, 0, 0, 0, 8'h99, 0, 0, 0, "t4_clamp_both");

        // 5: zero preset goes straight to DONE without expire
        step(1, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, "t5_load0");
        step(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0, "t5_start0");
        step(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0, "t5_restart0");

        // 6: auto-reload from DONE, stop in DONE, load interactions
        step(1, 8'h02, 0, 0, 0, 8'h02, 0, 0, 0, "t6_load");
        step(0, 8'h00, 1, 0, 0, 8'h02, 1, 0, 0, "t6_start");
        step(0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0, "t6_tick1");
        step(0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 1, "t6_expire1");
        step(0, 8'h00, 1, 0, 0, 8'h02, 1, 0, 0, "t6_reload");
        step(0, 8'h00, 0, 0, 1, 8'h01, 1, 0, 0, "t6_tick2");
        step(0, 8'h00, 0, 0, 1, 8'h00, 0, 1, 1, "t6_expire2");
        step(0, 8'h00, 0, 1, 0, 8'h00, 0, 0, 0, "t6_stop_done");
        step(1, 8'h45, 0, 0, 1, 8'h45, 0, 0, 0, "t6_load_tick");
        step(0, 8'h00, 1, 0, 0, 8'h45, 1, 0, 0, "t6_start45");
        step(1, 8'h30, 0, 0, 1, 8'h30, 0, 0, 0, "t6_load_in_run");
        step(0, 8'h00, 1, 0, 0, 8'h30, 1, 0, 0, "t6_start30");
        step(0, 8'h00, 0, 0, 1, 8'h29, 1, 0, 0, "t6_tick30");

        // 1b: asynchronous reset mid-RUN, checked before any clock edge
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        push_exp(8'h00, 1'b0, 1'b0, 1'b0, "reset_mid_run");
        -> chk_now;
        #1;
        rst = 1'b1;
        step(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0, "preset_cleared");

        repeat (2) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Multi-digit BCD down-counter. It is the count-down counterpart of the lab's BCD up-counter: it consumes a loaded BCD preset and decrements it in BCD on each qualified tick, chaining borrow across digits. A small control FSM (IDLE/RUN/DONE) supports start, pause and auto-reload. It drives seven-segment decoders directly and flags expiry to the system-level controller.

Parameters:
DIGITS, 2, number of BCD digits (1..4); count width is 4*DIGITS.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
load  input  1  synchronous load strobe; captures din into preset and count.
din  input  4*DIGITS  BCD preset value; digit i occupies bits [4i+3:4i].
start  input  1  start or resume counting.
stop  input  1  pause counting; count is held.
tick  input  1  count-enable strobe, e.g. a 1 Hz prescaler pulse, one clk wide.
Y  output  4*DIGITS  current BCD count.
running  output  1  high while the FSM is in RUN.
done  output  1  high while the FSM is in DONE (count = 0 after expiry).
expire  output  1  one-cycle pulse on the clk edge where the count reaches zero from RUN.

Behaviour:
- Reset (rst=0, asynchronous):
  - Y = 0, preset = 0, state = IDLE.
  - running = 0, done = 0, expire = 0.
- All other updates happen on the rising edge of clk.
- Input sanitising: any din digit > 9 is clamped to 9 when it is loaded.
- Priority order: load > stop > start > tick.
- load, in any state:
  - preset and Y take the clamped din.
  - state moves to IDLE; expire = 0.
  - A tick in the same cycle is ignored.
- IDLE:
  - start=1 and Y != 0 -> RUN.
  - start=1 and Y == 0 -> DONE, with no expire pulse.
  - Otherwise hold.
- RUN:
  - stop=1 -> IDLE, Y held; this is the pause, and start resumes.
  - Otherwise, tick=1 decrements Y by 1 in BCD:
    - Digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
    - Digits not reached by a borrow are unchanged.
  - If the decrement takes Y to 0 -> DONE, with expire=1 for that single cycle.
  - tick=0 -> hold.
  - Y never wraps below 0 in RUN.
- DONE:
  - Y = 0.
  - start=1 -> Y reloaded from preset. Then RUN if preset != 0, else remain DONE.
  - stop in DONE -> IDLE.
- Simultaneous start and stop: stop wins in RUN and in DONE. In IDLE, stop is a no-op and start is honoured.
- Latency: Y updates on the same edge that samples tick; there is no pipeline stage.
- running and done are registered decodes of the state; expire is a registered pulse.
- Reset mid-count aborts immediately. preset is lost (cleared to 0).

Decomposition:
- Shared package (header include): state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, and BCD_MAX=4'd9.
- Sub-module bcd_down_digit, one per digit through a generate loop:
  - Inputs: digit value, borrow_in.
  - Outputs: next digit, borrow_out.
  - borrow_out = borrow_in & (digit == 0).
  - Digit 0 gets borrow_in = decrement enable.
- Top level holds the FSM, the preset register, the clamp logic and the zero-detect.

Test Plan:
1. DIGITS=2; rst low then high -> Y=8'h00, running=0, done=0, expire=0. Assert rst mid-RUN -> same values immediately, without waiting for a clock edge.
2. load din=8'h12, start, 12 ticks -> Y sequence 12,11,10,09,...,01,00. expire pulses once on the 12th tick; done=1 afterwards, running=0.
3. load 8'h20, start, 1 tick -> Y=8'h19 (cross-digit borrow). Assert stop, then tick x3 -> Y stays 19. start, 1 tick -> 18.
4. load 8'h3C (digit0 invalid) -> Y=8'h39.
5. load 8'h00, start -> DONE with no expire pulse.
6. load 8'h02, run to DONE, then start -> Y reloads 02, running=1, 2 ticks -> expire again. Also: start and stop together in RUN -> IDLE; load and tick together -> Y=din, no decrement.
